// File: rtl/fetch_queue_unit.sv
// Prefetching instruction unit: a PC-tagged queue fed from synchronous instruction memory and
// drained into IR. Branch, jump and register redirects flush the queue and take one FLUSH cycle.
module fetch_queue_unit #(
    parameter int            AW       = 32,
    parameter int            IM_AW    = 12,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_en,
    output logic          im_cs,
    output logic          im_rd,
    output logic [AW-1:0] im_addr,
    input  logic [31:0]   im_rdata,
    input  logic          ir_ld,
    output logic          q_valid,
    input  logic          pc_ld,
    input  logic [1:0]    pc_sel,
    input  logic [AW-1:0] PC_in,
    output logic [31:0]   IR_out,
    output logic [AW-1:0] PC_out,
    output logic [31:0]   SE_16
);
    localparam int          PW      = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    typedef enum logic {FETCH, FLUSH} state_t;

    state_t               state;
    logic [AW-1:0]        fpc;
    logic [AW-1:0]        req_pc;
    logic                 inflight;
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [PW:0]          count;
    logic [31:0]          q_data [DEPTH];
    logic [AW-1:0]        q_pc   [DEPTH];

    logic                 redirect;
    logic                 push;
    logic                 pop;
    logic [AW-1:0]        p4;
    logic signed [31:0]   br_off;
    logic [AW-1:0]        br_target;
    logic [AW-1:0]        jmp_target;
    logic [AW-1:0]        target;

    assign redirect = pc_ld && (pc_sel != 2'b11);
    assign push     = inflight && (state == FETCH) && !redirect;
    assign pop      = ir_ld && q_valid && !redirect;
    assign q_valid  = (count != '0);

    // The in-flight slot is reserved up front so a full queue can never be overrun.
    assign im_rd    = !reset && (state == FETCH) && fetch_en && !redirect &&
                      ((count + {{PW{1'b0}}, inflight}) < DEPTH_C);
    assign im_cs    = im_rd;
    assign im_addr  = AW'(fpc[IM_AW-1:0]);

    assign SE_16     = {{16{IR_out[15]}}, IR_out[15:0]};
    assign p4        = PC_out + AW'(4);
    assign br_off    = {SE_16[29:0], 2'b00};
    assign br_target = p4 + AW'(br_off);

    always_comb begin
        jmp_target       = p4;
        jmp_target[27:0] = {IR_out[25:0], 2'b00};
        target           = PC_in;
        case (pc_sel)
            2'b00:   target = br_target;
            2'b01:   target = jmp_target;
            default: target = PC_in;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            fpc      <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            IR_out   <= '0;
            PC_out   <= RESET_PC;
        end else if (redirect) begin
            // Dropping inflight here discards the response that lands during FLUSH.
            state    <= FLUSH;
            fpc      <= target;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            state    <= FETCH;
            inflight <= im_rd;
            if (im_rd) begin
                fpc    <= fpc + AW'(4);
                req_pc <= fpc;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head   <= head + 1'b1;
                IR_out <= q_data[head];
                PC_out <= q_pc[head];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[tail] <= im_rdata;
            q_pc[tail]   <= req_pc;
        end
    end
endmodule
